leaf_stream_sender: RTL and testbench
=====================================

# leaf_stream_sender

Credit-based transmitter for the BFT leaf protocol. Accepts a 32-bit valid/ack user stream and injects 49-bit data packets into the BFT, addressed to one input port of a remote leaf whose receive buffer is NUM_BRAM_ADDR_BITS deep. Consumes freespace (credit) packets returned by that remote leaf, so the sender never overruns the receive buffer. Sits on the host/producer side of a page, opposite the receiving leaf interface of a user operator.

## Interface
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 4, leaf address field width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, packet buffer-address field width
- NUM_BRAM_ADDR_BITS, 7, remote buffer depth = 2^7 = 128 slots
- FREESPACE_UPDATE_SIZE, 64, largest legal credit increment in one credit packet
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dst_leaf  in  4  destination leaf, sampled per accepted beat
- dst_port  in  4  destination port, must be nonzero (port 0 is reserved for control)
- din_user  in  32  stream data
- vld_user  in  1  stream valid
- ack_user  out  1  stream ready; beat transfers when vld_user && ack_user
- dout_leaf_interface2bft  out  49  packet to BFT
- din_leaf_bft2interface  in  49  packet from BFT (credit packets)
- resend  in  1  BFT did not take the presented packet; hold it
- credit_count  out  8  current free remote slots, 0..128
- err_credit_overflow  out  1  sticky, credit return beyond 128

## Operation
- Packet format: [48] valid, [47:44] leaf, [43:40] port, [39:33] address, [32] reserved 0, [31:0] payload.
- Data packet: valid=1, leaf=dst_leaf, port=dst_port, address=send pointer, payload=din_user.
- Credit packet (input): [48]=1 and [43:40]=0; increment = [7:0] of payload. Any other input packet is ignored.
- ack_user = (credit_count != 0) && !resend.
- On accepted beat: output register loaded with data packet; send pointer (7-bit) increments, wrapping 127->0; credit decrements by 1.
- Cycle with no accepted beat and resend=0: output register loads all zeros (valid bit 0).
- resend=1: output register holds its value, no beat accepted, pointer and credit unchanged by send.
- Credit update each cycle: next = credit - send + inc. Credits arriving during resend are still applied.
- If next > 128: credit saturates at 128, err_credit_overflow set; cleared only by reset.
- Increments above FREESPACE_UPDATE_SIZE are applied as given (the receiver never sends them); overflow rule still applies.
- Reset: dout_leaf_interface2bft=0, credit_count=128, send pointer=0, err_credit_overflow=0, ack_user=0 during the reset cycle. Reset mid-stream discards the in-flight packet; no partial state survives.

## Timing
- Beat accepted in cycle t appears on dout_leaf_interface2bft in cycle t+1, for exactly one cycle unless resend is high.
- resend high in cycle t: packet shown in t is shown again in t+1.
- Credit packet present in cycle t: credit_count updated at t+1; ack_user may rise in t+1.
- Throughput: 1 packet/cycle while credit > 0 and resend=0.
- ack_user is combinational from registered credit_count and resend; no combinational path from vld_user to ack_user.

## Test plan
- Reset, then vld_user=1 with din_user=0xA5A5_0001, dst_leaf=3, dst_port=2 -> next cycle dout = {1,4'd3,4'd2,7'd0,1'b0,32'hA5A50001}; credit_count 127.
- Stream 130 beats with no credit return -> exactly 128 packets, addresses 0..127, ack_user low after the 128th; credit_count 0; beats 129-130 held by source.
- At credit 0, inject credit packet (port 0, payload 64) -> credit_count 64 next cycle; sending resumes with address 0 (wrap).
- At credit 1, same cycle: accepted beat plus credit increment 64 -> credit_count 64.
- resend high 3 cycles after a packet launch -> same packet on dout for 4 cycles, ack_user low, pointer unchanged; then continues with the next address.
- At credit 128, credit packet with increment 1 -> credit stays 128, err_credit_overflow=1 and sticky; reset mid-stream -> dout=0, credit 128, error cleared.

Source files
------------

// File: rtl/leaf_stream_sender.sv
// Credit-based BFT leaf transmitter: packs a valid/ack user stream into 49-bit packets and tracks
// free slots in the remote receive buffer from returned credit packets. One-cycle launch latency.
module leaf_stream_sender #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 4,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LEAF_BITS-1:0]      dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dst_port,
    input  logic [PAYLOAD_BITS-1:0]       din_user,
    input  logic                          vld_user,
    output logic                          ack_user,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    input  logic                          resend,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit_count,
    output logic                          err_credit_overflow
);

    localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int SUM_BITS    = CREDIT_BITS + 2;
    localparam int PORT_LSB    = PAYLOAD_BITS + 1 + NUM_ADDR_BITS;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

    if (FREESPACE_UPDATE_SIZE > (1 << NUM_BRAM_ADDR_BITS)) begin : g_bad_update_size
        $error("credit update size exceeds remote buffer depth");
    end

    logic [CREDIT_BITS-1:0]   credit;
    logic [NUM_ADDR_BITS-1:0] send_ptr;
    logic [PACKET_BITS-1:0]   dout_q;
    logic                     err_q;
    logic                     beat;
    logic                     is_credit;
    logic [CREDIT_BITS-1:0]   inc;
    logic [SUM_BITS-1:0]      credit_next;
    logic                     unused_din_bits;

    assign ack_user  = !reset && (credit != '0) && !resend;
    assign beat      = vld_user && ack_user;

    // Only valid packets addressed to port 0 carry credit; everything else from the BFT is dropped.
    assign is_credit = din_leaf_bft2interface[PACKET_BITS-1] &&
                       (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0);
    assign inc       = is_credit ? din_leaf_bft2interface[CREDIT_BITS-1:0] : '0;

    assign credit_next = {2'b00, credit} + {2'b00, inc} - {{(SUM_BITS-1){1'b0}}, beat};

    assign unused_din_bits = ^{din_leaf_bft2interface[PACKET_BITS-2:PORT_LSB+NUM_PORT_BITS],
                               din_leaf_bft2interface[PORT_LSB-1:CREDIT_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= '0;
            credit   <= CREDIT_MAX;
            send_ptr <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!resend) begin
                dout_q <= beat ? {1'b1, dst_leaf, dst_port, send_ptr, 1'b0, din_user} : '0;
            end
            if (beat) begin
                send_ptr <= send_ptr + NUM_ADDR_BITS'(1);
            end
            // Saturate rather than wrap so a misbehaving receiver cannot make us overrun its buffer.
            if (credit_next > {2'b00, CREDIT_MAX}) begin
                credit <= CREDIT_MAX;
                err_q  <= 1'b1;
            end else begin
                credit <= credit_next[CREDIT_BITS-1:0];
            end
        end
    end

    assign dout_leaf_interface2bft = dout_q;
    assign credit_count            = credit;
    assign err_credit_overflow     = err_q;

endmodule

// File: tb/tb_leaf_stream_sender.sv
// Bench for leaf_stream_sender: directed scenarios plus randomized traffic, all checked every
// cycle against a credit/packet model, with literal expectations pinning key points.
module tb_leaf_stream_sender;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dst_leaf;
    logic [3:0]  dst_port;
    logic [31:0] din_user;
    logic        vld_user;
    logic        ack_user;
    logic [48:0] dout;
    logic [48:0] din_bft;
    logic        resend;
    logic [7:0]  credit_count;
    logic        err;

    always #5 clk = ~clk;

    leaf_stream_sender dut (
        .clk                     (clk),
        .reset                   (reset),
        .dst_leaf                (dst_leaf),
        .dst_port                (dst_port),
        .din_user                (din_user),
        .vld_user                (vld_user),
        .ack_user                (ack_user),
        .dout_leaf_interface2bft (dout),
        .din_leaf_bft2interface  (din_bft),
        .resend                  (resend),
        .credit_count            (credit_count),
        .err_credit_overflow     (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: free remote slots, next buffer address, packet on the wire, sticky error.
    bit          m_init = 1'b0;
    int          m_credit;
    int          m_ptr;
    logic [48:0] m_dout;
    bit          m_err;

    int          pkt_cnt;
    int          last_addr;

    function automatic logic [48:0] data_pkt(input logic [3:0] l, input logic [3:0] p,
                                             input int a, input logic [31:0] d);
        logic [6:0] a7;
        a7 = a[6:0];
        return {1'b1, l, p, a7, 1'b0, d};
    endfunction

    function automatic logic [48:0] credit_pkt(input int n, input logic [23:0] junk);
        logic [7:0] n8;
        n8 = n[7:0];
        return {1'b1, 4'd0, 4'd0, 7'd0, 1'b0, junk, n8};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare all outputs against the model, then advance the model by the spec rules.
    task automatic cycle();
        bit m_ack;
        bit accepted;
        int inc;
        int nc;
        #1;
        m_ack = !reset && m_init && (m_credit > 0) && !resend;
        if (reset) check("ack_in_reset", 64'(ack_user), 64'd0);
        if (m_init) begin
            check("ack", 64'(ack_user), 64'(m_ack));
            check("dout", 64'(dout), 64'(m_dout));
            check("credit", 64'(credit_count), 64'(m_credit));
            check("err", 64'(err), 64'(m_err));
            if (dout[48]) begin
                pkt_cnt++;
                last_addr = int'(dout[39:33]);
            end
        end
        @(posedge clk);
        if (reset) begin
            m_init = 1'b1;
            m_credit = 128;
            m_ptr = 0;
            m_dout = '0;
            m_err = 1'b0;
        end else if (m_init) begin
            accepted = vld_user && m_ack;
            inc = (din_bft[48] && din_bft[43:40] == 4'd0) ? int'(din_bft[7:0]) : 0;
            if (!resend) m_dout = accepted ? data_pkt(dst_leaf, dst_port, m_ptr, din_user) : '0;
            if (accepted) m_ptr = (m_ptr + 1) % 128;
            nc = m_credit - (accepted ? 1 : 0) + inc;
            if (nc > 128) begin
                nc = 128;
                m_err = 1'b1;
            end
            m_credit = nc;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        vld_user = 1'b0;
        resend = 1'b0;
        din_bft = '0;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic drive_random();
        int r;
        reset    = ($urandom_range(299) == 0);
        vld_user = ($urandom_range(99) < 70);
        din_user = $urandom;
        dst_leaf = 4'($urandom_range(15));
        dst_port = 4'($urandom_range(15, 1));
        resend   = ($urandom_range(99) < 15);
        r = $urandom_range(99);
        if (r < 15)
            din_bft = credit_pkt($urandom_range(70), 24'($urandom));
        else if (r < 20)
            din_bft = {1'b1, 4'($urandom), 4'($urandom_range(15, 1)), 40'({$urandom, $urandom})};
        else if (r < 25)
            din_bft = {1'b0, 4'($urandom), 4'd0, 40'({$urandom, $urandom})};
        else
            din_bft = '0;
    endtask

    logic [48:0] held;

    initial begin
        reset = 1'b1; vld_user = 1'b0; resend = 1'b0; din_bft = '0;
        din_user = '0; dst_leaf = 4'd0; dst_port = 4'd1;
        @(negedge clk);
        do_reset(2);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_credit", 64'(credit_count), 64'd128);
        check("rst_err", 64'(err), 64'd0);

        // First beat lands on the wire one cycle later with address 0.
        vld_user = 1'b1; din_user = 32'hA5A5_0001; dst_leaf = 4'd3; dst_port = 4'd2;
        cycle();
        vld_user = 1'b0;
        check("first_pkt", 64'(dout), 64'h1_3200_A5A5_0001);
        check("first_credit", 64'(credit_count), 64'd127);

        // 130 offered beats with no credit return: only 128 go out.
        do_reset(1);
        pkt_cnt = 0;
        dst_leaf = 4'd5; dst_port = 4'd7;
        for (int i = 0; i < 130; i++) begin
            vld_user = 1'b1; din_user = 32'(i);
            cycle();
        end
        check("stream_pkts", 64'(pkt_cnt), 64'd128);
        check("stream_last_addr", 64'(last_addr), 64'd127);
        check("stream_credit", 64'(credit_count), 64'd0);
        check("stream_ack_low", 64'(ack_user), 64'd0);

        // Credit return at zero, then the pointer wraps to 0.
        vld_user = 1'b0; din_bft = credit_pkt(64, 24'h00_0000);
        cycle();
        din_bft = '0;
        check("credit_return", 64'(credit_count), 64'd64);
        vld_user = 1'b1; din_user = 32'hCAFE_0000;
        cycle();
        vld_user = 1'b0;
        check("wrap_addr", 64'(dout[39:33]), 64'd0);
        check("wrap_vld", 64'(dout[48]), 64'd1);

        // Drain to credit 1, then send and receive credit in the same cycle.
        for (int i = 0; i < 62; i++) begin
            vld_user = 1'b1; din_user = 32'(1000 + i);
            cycle();
        end
        check("credit_one", 64'(credit_count), 64'd1);
        vld_user = 1'b1; din_bft = credit_pkt(64, 24'h12_3456);
        cycle();
        din_bft = '0;
        check("send_and_credit", 64'(credit_count), 64'd64);

        // Launch then hold with resend for three cycles.
        vld_user = 1'b1; din_user = 32'h0BAD_F00D;
        cycle();
        held = m_dout;
        check("launch_addr", 64'(held[39:33]), 64'd64);
        check("launch_pkt", 64'(dout), 64'(held));
        for (int i = 0; i < 3; i++) begin
            resend = 1'b1; vld_user = 1'b1;
            #1 check("resend_ack_low", 64'(ack_user), 64'd0);
            cycle();
            check("resend_hold", 64'(dout), 64'(held));
        end
        resend = 1'b0; vld_user = 1'b1; din_user = 32'h1234_5678;
        cycle();
        vld_user = 1'b0;
        check("after_resend_addr", 64'(dout[39:33]), 64'd65);
        check("after_resend_pld", 64'(dout[31:0]), 64'h1234_5678);

        // Credit beyond capacity saturates and latches the error.
        do_reset(1);
        din_bft = credit_pkt(1, 24'h00_0000);
        cycle();
        din_bft = '0;
        check("ovf_credit", 64'(credit_count), 64'd128);
        check("ovf_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            vld_user = 1'b1; din_user = 32'(i);
            cycle();
        end
        check("ovf_err_sticky", 64'(err), 64'd1);

        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        // Reset while streaming discards everything.
        reset = 1'b0; resend = 1'b0; din_bft = credit_pkt(200, 24'h0);
        vld_user = 1'b1;
        cycle();
        din_bft = '0;
        reset = 1'b1; vld_user = 1'b1;
        cycle();
        reset = 1'b0; vld_user = 1'b0;
        check("midrst_dout", 64'(dout), 64'd0);
        check("midrst_credit", 64'(credit_count), 64'd128);
        check("midrst_err", 64'(err), 64'd0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
